// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a pending-write scoreboard.
// Ports: clk, rst (async, active-high); rd_addr/rd_data/src_used are the
// NRD packed read ports; issue_valid/issue_we/issue_rd/issue_ready form the
// issue handshake; wb_valid/wb_rd/wb_data are the writeback port; flush drops
// all outstanding writes; pending and busy_cnt report scoreboard state.
// Option: define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data
// to the read ports and clear the matching source hazards.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NRD-1:0]      src_used,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [NREGS-1:0]    pending,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] clear_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] pending_nxt;
    logic [NRD-1:0]   byp_hit;
    logic [NRD-1:0]   src_haz;
    logic             waw;
    logic             accept;
    logic [AW:0]      cnt_nxt;

    // Read ports and per-source hazard detection.
    always_comb begin
        rd_data = '0;
        byp_hit = '0;
        src_haz = '0;
        for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_SB_BYPASS_EN
            byp_hit[i] = wb_valid
                      && (wb_rd == rd_addr[i*AW +: AW])
                      && (rd_addr[i*AW +: AW] != '0);
`else
            byp_hit[i] = 1'b0;
`endif
            // regs[0] is held at zero, so x0 needs no special read path.
            rd_data[i*XLEN +: XLEN] = byp_hit[i]
                ? wb_data
                : regs[rd_addr[i*AW +: AW]];
            src_haz[i] = src_used[i]
                      && pending[rd_addr[i*AW +: AW]]
                      && (rd_addr[i*AW +: AW] != '0)
                      && !byp_hit[i];
        end
    end

    // A redundant write to a register that retires this very cycle is
    // not a WAW hazard: the old write clears as the new one sets.
    always_comb begin
        waw = issue_we
           && (issue_rd != '0)
           && pending[issue_rd]
           && !(wb_valid && (wb_rd == issue_rd));
        issue_ready = !flush && !(|src_haz) && !waw;
        accept      = issue_valid && issue_ready;
    end

    // Clear is applied before set so a same-register set wins.
    always_comb begin
        clear_vec = '0;
        set_vec   = '0;
        if (wb_valid)
            clear_vec[wb_rd] = 1'b1;
        if (accept && issue_we && (issue_rd != '0))
            set_vec[issue_rd] = 1'b1;
        if (flush)
            pending_nxt = '0;
        else
            pending_nxt = (pending & ~clear_vec) | set_vec;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pending_nxt[r]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            busy_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (wb_valid && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

endmodule
